// File: rtl/trng_io_pkg.sv
// Shared definitions for the TRNG I/O bridge: register map, STATUS layout,
// bus FSM states and a level-to-byte helper.
package trng_io_pkg;

    localparam logic [3:0] OFF_RX_DATA = 4'h0;
    localparam logic [3:0] OFF_TX_DATA = 4'h4;
    localparam logic [3:0] OFF_STATUS  = 4'h8;
    localparam logic [3:0] OFF_OVF_CNT = 4'hC;

    localparam int ST_RX_EMPTY   = 0;
    localparam int ST_RX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_TX_FULL    = 3;
    localparam int ST_TX_ERR     = 4;
    localparam int ST_RX_LVL_LSB = 8;
    localparam int ST_TX_LVL_LSB = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_t;

    // A 256-deep FIFO holds 256 words, which does not fit the 8-bit field.
    function automatic logic [7:0] level_byte(input logic [8:0] level);
        return (level > 9'd255) ? 8'hFF : level[7:0];
    endfunction

endpackage

// File: rtl/trng_io_bridge_if.sv
// picorv32-native memory bus between the CPU (master) and the bridge (slave).
interface trng_io_bridge_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_sel, mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_sel, mem_ready, mem_rdata
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop frees a full slot for a
// push in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/trng_io_bridge.sv
// Bridges a TRNG word stream and a button-driven output FIFO onto a picorv32
// bus window. Optional overflow counter: define TRNG_IO_BRIDGE_OVF_CNT_EN.
module trng_io_bridge
    import trng_io_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            trng_data,
    input  logic                   trng_valid,
    trng_io_bridge_if.slave        bus,
    input  logic                   button,
    output logic [31:0]            data_out,
    output logic                   rx_full,
    output logic                   rx_empty,
    output logic                   tx_full,
    output logic                   tx_empty
);
    localparam int LW = $clog2(DEPTH) + 1;

    bus_state_t  state, state_next;
    logic        accept;
    logic        is_write;
    logic [3:0]  offset;
    logic [31:0] rdata_next, rdata_q, status;
    logic [31:0] rx_head, tx_head;
    logic [LW-1:0] rx_level, tx_level;
    logic        rx_pop, rx_drop, tx_push, tx_pop, tx_drop;
    logic        status_clr, tx_err;
    logic        btn_p0, btn_p1, btn_p2, pop_req_p3;

    assign bus.mem_sel = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign is_write    = |bus.mem_wstrb;
    assign offset      = bus.mem_addr[3:0];
    assign rx_pop      = accept && !is_write && (offset == OFF_RX_DATA);
    assign tx_push     = accept &&  is_write && (offset == OFF_TX_DATA);
    assign status_clr  = accept &&  is_write && (offset == OFF_STATUS);
    assign tx_pop      = pop_req_p3;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .resetn(resetn), .push(trng_valid), .wdata(trng_data),
        .pop(rx_pop), .head(rx_head), .level(rx_level),
        .full(rx_full), .empty(rx_empty), .drop(rx_drop)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .resetn(resetn), .push(tx_push), .wdata(bus.mem_wdata),
        .pop(tx_pop), .head(tx_head), .level(tx_level),
        .full(tx_full), .empty(tx_empty), .drop(tx_drop)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (bus.mem_sel) begin
                accept     = 1'b1;
                state_next = RESP;
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        status = '0;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_ERR]   = tx_err;
        status[ST_RX_LVL_LSB +: 8] = level_byte(9'(rx_level));
        status[ST_TX_LVL_LSB +: 8] = level_byte(9'(tx_level));
    end

`ifdef TRNG_IO_BRIDGE_OVF_CNT_EN
    logic [15:0] ovf_cnt;
    logic        ovf_clr;

    assign ovf_clr = accept && is_write && (offset == OFF_OVF_CNT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                           ovf_cnt <= '0;
        else if (ovf_clr)                      ovf_cnt <= 16'(rx_drop);
        else if (rx_drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
`else
    logic unused_rx_drop;
    assign unused_rx_drop = rx_drop;
`endif

    always_comb begin
        rdata_next = '0;
        if (!is_write) begin
            case (offset)
                OFF_RX_DATA: rdata_next = rx_empty ? '0 : rx_head;
                OFF_STATUS:  rdata_next = status;
`ifdef TRNG_IO_BRIDGE_OVF_CNT_EN
                OFF_OVF_CNT: rdata_next = {16'd0, ovf_cnt};
`endif
                default:     rdata_next = '0;
            endcase
        end
    end

    // Response is captured at accept so it reflects state before the commit.
    always_ff @(posedge clk) begin
        if (accept) rdata_q <= rdata_next;
    end

    assign bus.mem_ready = (state == RESP);
    assign bus.mem_rdata = (state == RESP) ? rdata_q : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         tx_err <= 1'b0;
        else if (tx_drop)    tx_err <= 1'b1;
        else if (status_clr) tx_err <= 1'b0;
    end

    // Two-flop synchroniser, edge register, then registered pop request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_p0     <= 1'b0;
            btn_p1     <= 1'b0;
            btn_p2     <= 1'b0;
            pop_req_p3 <= 1'b0;
        end else begin
            btn_p0     <= button;
            btn_p1     <= btn_p0;
            btn_p2     <= btn_p1;
            pop_req_p3 <= btn_p1 && !btn_p2;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                  data_out <= '0;
        else if (tx_pop && !tx_empty) data_out <= tx_head;
    end
endmodule

// File: tb/tb_trng_io_bridge.sv
// Directed + randomized bench for trng_io_bridge against a queue-based model.
module tb_trng_io_bridge;
    localparam int DEPTH = 16;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] trng_data = '0;
    logic        trng_valid = 1'b0;
    logic        button = 1'b0;
    logic [31:0] data_out;
    logic        rx_full, rx_empty, tx_full, tx_empty;

    trng_io_bridge_if bus ();

    trng_io_bridge #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn), .trng_data(trng_data), .trng_valid(trng_valid),
        .bus(bus), .button(button), .data_out(data_out),
        .rx_full(rx_full), .rx_empty(rx_empty), .tx_full(tx_full), .tx_empty(tx_empty)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    logic        m_tx_err = 1'b0;
    int          m_ovf = 0;
    logic [31:0] m_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (rxq.size() == 0);
        s[1] = (rxq.size() == DEPTH);
        s[2] = (txq.size() == 0);
        s[3] = (txq.size() == DEPTH);
        s[4] = m_tx_err;
        s[15:8]  = 8'(rxq.size());
        s[23:16] = 8'(txq.size());
        return s;
    endfunction

    function automatic logic [31:0] m_ovf_read();
`ifdef TRNG_IO_BRIDGE_OVF_CNT_EN
        return 32'(m_ovf);
`else
        return 32'd0;
`endif
    endfunction

    function automatic void m_trng(input logic [31:0] w);
        if (rxq.size() < DEPTH) rxq.push_back(w);
        else if (m_ovf < 16'hFFFF) m_ovf++;
    endfunction

    task automatic trng_word(input logic [31:0] w);
        @(negedge clk);
        trng_valid = 1'b1;
        trng_data  = w;
        @(posedge clk);
        #1;
        trng_valid = 1'b0;
        m_trng(w);
    endtask

    task automatic bus_op(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic with_trng,
                          input logic [31:0] tword);
        logic [31:0] exp;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        trng_valid    = with_trng;
        trng_data     = tword;
        #1;
        chk("mem_sel_hit", 32'(bus.mem_sel), 32'd1);
        chk("ready_before", 32'(bus.mem_ready), 32'd0);
        exp = '0;
        if (wstrb == 4'd0) begin
            case (addr[3:0])
                4'h0: if (rxq.size() > 0) exp = rxq.pop_front();
                4'h8: exp = m_status();
                4'hC: exp = m_ovf_read();
                default: exp = '0;
            endcase
        end else begin
            case (addr[3:0])
                4'h4: if (txq.size() < DEPTH) txq.push_back(wdata); else m_tx_err = 1'b1;
                4'h8: m_tx_err = 1'b0;
                4'hC: m_ovf = 0;
                default: ;
            endcase
        end
        if (with_trng) m_trng(tword);
        @(posedge clk);
        #1;
        trng_valid = 1'b0;
        chk("ready_resp", 32'(bus.mem_ready), 32'd1);
        chk("rdata", bus.mem_rdata, exp);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = '0;
        @(posedge clk);
        #1;
        chk("ready_after", 32'(bus.mem_ready), 32'd0);
        chk("rdata_after", bus.mem_rdata, 32'd0);
    endtask

    task automatic rd(input logic [3:0] off);
        bus_op(BASE + 32'(off), 32'd0, 4'd0, 1'b0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        bus_op(BASE + 32'(off), d, 4'hF, 1'b0, 32'd0);
    endtask

    task automatic press(input int hold);
        logic [31:0] old_v, new_v;
        old_v = m_dout;
        new_v = (txq.size() > 0) ? txq[0] : m_dout;
        @(negedge clk);
        button = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("dout_early", data_out, old_v);
        @(posedge clk);
        #1;
        chk("dout_edge4", data_out, new_v);
        if (txq.size() > 0) void'(txq.pop_front());
        m_dout = new_v;
        repeat (hold - 4) @(posedge clk);
        @(negedge clk);
        button = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("dout_held", data_out, m_dout);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        chk("rst_flags", {28'd0, rx_empty, rx_full, tx_empty, tx_full}, 32'b1010);
        @(negedge clk);
        resetn = 1'b1;

        // Overfill the input FIFO.
        for (int i = 0; i < 20; i++) trng_word($urandom);
        #1;
        chk("rx_full_pin", 32'(rx_full), 32'd1);
        rd(4'h8);
        rd(4'hC);

        // Pop and push together on a full input FIFO.
        bus_op(BASE, 32'd0, 4'd0, 1'b1, $urandom);
        rd(4'h8);
        rd(4'hC);

        for (int i = 0; i < DEPTH + 1; i++) rd(4'h0);
        trng_word(32'hA5A5_0001);
        rd(4'h8);
        rd(4'h0);
        rd(4'h8);

        // Overfill the output FIFO and clear the sticky error.
        for (int i = 0; i < DEPTH + 1; i++) wr(4'h4, $urandom);
        #1;
        chk("tx_full_pin", 32'(tx_full), 32'd1);
        rd(4'h8);
        wr(4'h8, 32'd0);
        rd(4'h8);
        wr(4'hC, 32'd0);
        rd(4'hC);
        rd(4'h4);

        for (int i = 0; i < DEPTH; i++) press(6);
        press(6);

        wr(4'h4, 32'h1234_5678);
        press(50);
        rd(4'h8);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: trng_word($urandom);
                1: bus_op(BASE, 32'd0, 4'd0, 1'($urandom_range(0, 1)), $urandom);
                2: bus_op(BASE + 32'h4, $urandom, 4'($urandom_range(1, 15)), 1'b0, 32'd0);
                3: rd(4'h8);
                4: rd(4'hC);
                default: press($urandom_range(5, 8));
            endcase
        end
        rd(4'h8);

        // Accesses outside the window are never answered.
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h2000_0000;
        bus.mem_wstrb = 4'd0;
        #1;
        chk("miss_sel", 32'(bus.mem_sel), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("miss_ready", 32'(bus.mem_ready), 32'd0);
        end
        bus.mem_addr = BASE + 32'h10;
        #1;
        chk("miss_sel_next", 32'(bus.mem_sel), 32'd0);
        bus.mem_valid = 1'b0;

        // Reset in the middle of a response aborts it.
        trng_word(32'hDEAD_BEEF);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + 32'h8;
        @(posedge clk);
        #1;
        chk("pre_abort_ready", 32'(bus.mem_ready), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.mem_ready), 32'd0);
        chk("abort_rdata", bus.mem_rdata, 32'd0);
        chk("abort_dout", data_out, 32'd0);
        chk("abort_flags", {28'd0, rx_empty, rx_full, tx_empty, tx_full}, 32'b1010);
        bus.mem_valid = 1'b0;
        rxq.delete();
        txq.delete();
        m_tx_err = 1'b0;
        m_ovf = 0;
        m_dout = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_abort_ready", 32'(bus.mem_ready), 32'd0);
        end
        rd(4'h8);
        rd(4'hC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
